// File: rtl/text_line_glyph_fetcher_if.sv
// Bundle between the glyph fetcher, its video timing source, the text
// buffer, the font ROM and the pixel serializer.
interface text_line_glyph_fetcher_if #(
    parameter int unsigned TXT_AW = 12
);
    logic              line_start;
    logic [3:0]        glyph_row;
    logic [TXT_AW-1:0] row_base;
    logic              busy;
    logic              overrun;
    logic              txt_rd;
    logic [TXT_AW-1:0] txt_addr;
    logic [7:0]        txt_data;
    logic              rom_ce;
    logic              rom_oce;
    logic [10:0]       rom_ad;
    logic [7:0]        rom_dout;
    logic [7:0]        px_data;
    logic              px_valid;
    logic              px_ready;
    logic              px_last;

    // Fetcher side
    modport master (
        input  line_start, glyph_row, row_base, txt_data, rom_dout, px_ready,
        output busy, overrun, txt_rd, txt_addr, rom_ce, rom_oce, rom_ad,
               px_data, px_valid, px_last
    );

    // Environment side (timing generator, memories, serializer)
    modport slave (
        output line_start, glyph_row, row_base, txt_data, rom_dout, px_ready,
        input  busy, overrun, txt_rd, txt_addr, rom_ce, rom_oce, rom_ad,
               px_data, px_valid, px_last
    );
endinterface

// File: rtl/text_line_glyph_fetcher.sv
// Per-line glyph fetcher: text buffer read -> font ROM read -> small FIFO
// -> valid/ready stream of glyph row bytes, one per text column.
module text_line_glyph_fetcher #(
    parameter int unsigned COLS       = 80,
    parameter int unsigned TXT_AW     = 12,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [7:0]  REPL_CHAR  = 8'h3F
) (
    input logic clk,
    input logic rst_n,
    text_line_glyph_fetcher_if.master bus
);
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = PW + 1;
    localparam logic [7:0] LAST_COL = 8'(COLS - 1);

    typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

    state_e            state_q;
    logic [3:0]        row_q;
    logic [TXT_AW-1:0] base_q;
    logic [7:0]        col_q;

    // Pipeline valid/last flags: stage 2 (ROM access), stage 3 (FIFO write)
    logic rom_ce_q, last2_q, wr_q, last3_q;

    logic [8:0]    mem_q [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;

    logic [1:0] inflight;
    logic       issue;
    logic       pop;
    logic [7:0] code;

    // Credit check: every issued column already owns a FIFO slot, so the FIFO can't overflow
    assign inflight = {1'b0, rom_ce_q} + {1'b0, wr_q};
    assign issue    = (state_q == StFetch) &&
                      ((32'(count_q) + 32'(inflight)) < FIFO_DEPTH);
    assign pop      = (count_q != '0) && bus.px_ready;
    assign code     = bus.txt_data[7] ? REPL_CHAR : bus.txt_data;

    assign bus.busy     = (state_q != StIdle);
    assign bus.overrun  = bus.line_start && (state_q != StIdle);
    assign bus.txt_rd   = issue;
    assign bus.txt_addr = issue ? (base_q + TXT_AW'(col_q)) : '0;
    assign bus.rom_ce   = rom_ce_q;
    assign bus.rom_oce  = 1'b1;
    assign bus.rom_ad   = rom_ce_q ? {code[6:0], row_q} : '0;
    assign bus.px_valid = (count_q != '0);
    assign bus.px_data  = (count_q != '0) ? mem_q[rd_ptr_q][7:0] : '0;
    assign bus.px_last  = (count_q != '0) ? mem_q[rd_ptr_q][8] : 1'b0;

    // Line FSM: latch line parameters, step columns, wait for the pipe and FIFO to empty
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            row_q   <= '0;
            base_q  <= '0;
            col_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.line_start) begin
                        state_q <= StFetch;
                        row_q   <= bus.glyph_row;
                        base_q  <= bus.row_base;
                        col_q   <= '0;
                    end
                end
                StFetch: begin
                    if (issue) begin
                        col_q <= col_q + 8'd1;
                        if (col_q == LAST_COL) state_q <= StDrain;
                    end
                end
                StDrain: begin
                    // Nothing in flight and the last FIFO byte leaves this cycle (or already left)
                    if (inflight == 2'd0 &&
                        (count_q == '0 || (count_q == CW'(1) && pop))) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Read pipeline: text read -> ROM access -> FIFO write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_ce_q <= 1'b0;
            last2_q  <= 1'b0;
            wr_q     <= 1'b0;
            last3_q  <= 1'b0;
        end else begin
            rom_ce_q <= issue;
            last2_q  <= issue && (col_q == LAST_COL);
            wr_q     <= rom_ce_q;
            last3_q  <= last2_q;
        end
    end

    // Output FIFO: glyph byte plus last-column flag per entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_q) begin
                mem_q[wr_ptr_q] <= {last3_q, bus.rom_dout};
                wr_ptr_q        <= wr_ptr_q + PW'(1);
            end
            if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({wr_q, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(wr_q && !pop && count_q == CW'(FIFO_DEPTH)));

endmodule

// File: tb/tb_text_line_glyph_fetcher.sv
// Directed bench for text_line_glyph_fetcher: a COLS=4 instance for timing,
// reset, substitution, overrun and address-wrap, a COLS=16 instance for backpressure.
module tb_text_line_glyph_fetcher;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;

    logic [7:0] tmem [4096];
    logic [7:0] rom  [2048];
    logic [8:0]  q4[$], q16[$];
    logic [11:0] a4[$];

    always #5 clk = ~clk;

    text_line_glyph_fetcher_if #(.TXT_AW(12)) b4 ();
    text_line_glyph_fetcher_if #(.TXT_AW(12)) b16 ();

    text_line_glyph_fetcher #(.COLS(4), .TXT_AW(12), .FIFO_DEPTH(4), .REPL_CHAR(8'h3F)) dut4 (
        .clk(clk), .rst_n(rst_n), .bus(b4));
    text_line_glyph_fetcher #(.COLS(16), .TXT_AW(12), .FIFO_DEPTH(4), .REPL_CHAR(8'h3F)) dut16 (
        .clk(clk), .rst_n(rst_n), .bus(b16));

    // Text buffer and font ROM models, 1-cycle read latency
    always @(posedge clk) begin
        if (b4.txt_rd)  b4.txt_data  <= tmem[b4.txt_addr];
        if (b16.txt_rd) b16.txt_data <= tmem[b16.txt_addr];
        if (b4.rom_ce)  b4.rom_dout  <= rom[b4.rom_ad];
        if (b16.rom_ce) b16.rom_dout <= rom[b16.rom_ad];
    end

    // Record accepted beats and issued text addresses
    always @(negedge clk) begin
        if (b4.px_valid && b4.px_ready)   q4.push_back({b4.px_last, b4.px_data});
        if (b16.px_valid && b16.px_ready) q16.push_back({b16.px_last, b16.px_data});
        if (b4.txt_rd) a4.push_back(b4.txt_addr);
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] exp_byte(input logic [7:0] c, input logic [3:0] r);
        logic [7:0] cc;
        cc = (c >= 8'h80) ? 8'h3F : c;
        return rom[{cc[6:0], r}];
    endfunction

    task automatic launch(input bit big, input logic [11:0] base, input logic [3:0] row);
        tick();
        if (big) begin
            b16.line_start = 1'b1; b16.row_base = base; b16.glyph_row = row;
        end else begin
            b4.line_start = 1'b1; b4.row_base = base; b4.glyph_row = row;
        end
        tick();
        b4.line_start = 1'b0;
        b16.line_start = 1'b0;
    endtask

    task automatic wait_idle(input bit big, input bit rnd, input int budget);
        int n;
        n = 0;
        @(negedge clk);
        while ((big ? b16.busy : b4.busy) && n < budget) begin
            tick();
            if (rnd) b4.px_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            n++;
        end
        b4.px_ready = 1'b1;
        chk("idle_timeout", 32'(n < budget), 32'd1);
    endtask

    task automatic check_line(input bit big, input logic [11:0] base, input logic [3:0] row,
                              input int n);
        logic [8:0] q[$];
        logic [8:0] got, exp;
        if (big) q = q16; else q = q4;
        chk("line_len", 32'(q.size()), 32'(n));
        for (int i = 0; i < n; i++) begin
            got = (i < q.size()) ? q[i] : 9'bx;
            exp = {i == n - 1, exp_byte(tmem[12'(base + 12'(i))], row)};
            chk($sformatf("beat%0d", i), 32'(got), 32'(exp));
        end
    endtask

    initial begin
        logic [10:0] ad_tbl [4];
        logic [11:0] wa_tbl [4];
        int issued;

        for (int i = 0; i < 2048; i++) rom[i] = 8'(i * 37 + (i >> 3));
        rom[11'h413] = 8'h38;
        for (int i = 0; i < 4096; i++) tmem[i] = 8'h20;
        tmem[12'h100] = "A"; tmem[12'h101] = "B"; tmem[12'h102] = "C"; tmem[12'h103] = "D";
        ad_tbl[0] = 11'h413; ad_tbl[1] = 11'h423; ad_tbl[2] = 11'h433; ad_tbl[3] = 11'h443;

        b4.line_start = 0;  b4.glyph_row = 0;  b4.row_base = 0;  b4.px_ready = 1;
        b16.line_start = 0; b16.glyph_row = 0; b16.row_base = 0; b16.px_ready = 1;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(b4.busy), 0);
        chk("rst_txt_rd", 32'(b4.txt_rd), 0);
        chk("rst_rom_ad", 32'(b4.rom_ad), 0);
        chk("rst_px_valid", 32'(b4.px_valid), 0);
        chk("rst_px_data", 32'(b4.px_data), 0);
        tick();
        rst_n = 1'b1;

        // Basic line: COLS=4, glyph_row=3, "ABCD", cycle-exact timing
        q4.delete();
        for (int k = 0; k <= 8; k++) begin
            tick();
            b4.line_start = (k == 0);
            b4.glyph_row = 4'd3;
            b4.row_base = 12'h100;
            @(negedge clk);
            if (k == 0) chk("t2_busy_c0", 32'(b4.busy), 0);
            if (k == 1) chk("t2_txt_rd_c1", 32'(b4.txt_rd), 1);
            if (k == 1) chk("t2_txt_addr_c1", 32'(b4.txt_addr), 32'h100);
            if (k >= 2 && k <= 5) chk($sformatf("t2_rom_ad_c%0d", k), 32'(b4.rom_ad),
                                      32'(ad_tbl[k-2]));
            if (k == 3) chk("t2_px_valid_c3", 32'(b4.px_valid), 0);
            if (k == 4) chk("t2_px_data_c4", 32'(b4.px_data), 32'h38);
            if (k >= 4 && k <= 7) chk($sformatf("t2_valid_c%0d", k), 32'(b4.px_valid), 1);
            if (k >= 4 && k <= 7) chk($sformatf("t2_last_c%0d", k), 32'(b4.px_last),
                                      32'(k == 7));
            if (k == 7) chk("t2_busy_c7", 32'(b4.busy), 1);
            if (k == 8) chk("t2_busy_c8", 32'(b4.busy), 0);
        end
        b4.line_start = 1'b0;
        check_line(0, 12'h100, 4'd3, 4);

        // Reset mid-FETCH, then a clean line
        for (int i = 0; i < 4; i++) tmem[12'h200 + 12'(i)] = 8'h61 + 8'(i);
        launch(0, 12'h200, 4'd5);
        tick();
        rst_n = 1'b0;
        #1;
        chk("t1_busy", 32'(b4.busy), 0);
        chk("t1_rom_ce", 32'(b4.rom_ce), 0);
        chk("t1_txt_rd", 32'(b4.txt_rd), 0);
        chk("t1_rom_ad", 32'(b4.rom_ad), 0);
        tick();
        rst_n = 1'b1;
        tick();
        q4.delete();
        launch(0, 12'h200, 4'd5);
        wait_idle(0, 0, 100);
        check_line(0, 12'h200, 4'd5, 4);

        // Code >= 0x80 replaced: 0x9B, glyph_row 7 -> rom_ad 0x3F7
        tmem[12'h040] = 8'h9B; tmem[12'h041] = 8'h7E; tmem[12'h042] = 8'hFF; tmem[12'h043] = 8'h00;
        q4.delete();
        launch(0, 12'h040, 4'd7);
        tick();
        @(negedge clk);
        chk("t4_rom_ce", 32'(b4.rom_ce), 1);
        chk("t4_rom_ad", 32'(b4.rom_ad), 32'h3F7);
        wait_idle(0, 0, 100);
        check_line(0, 12'h040, 4'd7, 4);

        // line_start while busy -> one-cycle overrun, line unchanged, no second line
        q4.delete();
        for (int k = 0; k <= 3; k++) begin
            tick();
            b4.line_start = (k == 0 || k == 2);
            b4.glyph_row = (k == 0) ? 4'd2 : 4'd9;
            b4.row_base = (k == 0) ? 12'h100 : 12'h040;
            @(negedge clk);
            if (k >= 1) chk($sformatf("t5_overrun_c%0d", k), 32'(b4.overrun), 32'(k == 2));
        end
        b4.line_start = 1'b0;
        wait_idle(0, 0, 100);
        check_line(0, 12'h100, 4'd2, 4);
        repeat (6) tick();
        @(negedge clk);
        chk("t5_no_second_line", 32'(b4.busy), 0);
        chk("t5_no_extra_beats", 32'(q4.size()), 4);

        // Address wrap with random px_ready
        tmem[12'hFFE] = "W"; tmem[12'hFFF] = 8'hC1; tmem[12'h000] = "0"; tmem[12'h001] = "1";
        wa_tbl[0] = 12'hFFE; wa_tbl[1] = 12'hFFF; wa_tbl[2] = 12'h000; wa_tbl[3] = 12'h001;
        q4.delete();
        a4.delete();
        launch(0, 12'hFFE, 4'd11);
        wait_idle(0, 1, 300);
        chk("t6_addr_cnt", 32'(a4.size()), 4);
        for (int i = 0; i < 4; i++)
            chk($sformatf("t6_addr%0d", i), 32'((i < a4.size()) ? a4[i] : 12'bx),
                32'(wa_tbl[i]));
        check_line(0, 12'hFFE, 4'd11, 4);

        // Backpressure on the COLS=16 instance
        for (int i = 0; i < 16; i++) tmem[12'h300 + 12'(i)] = 8'h30 + 8'(i * 5);
        q16.delete();
        b16.px_ready = 1'b0;
        launch(1, 12'h300, 4'd13);
        issued = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (b16.txt_rd) issued++;
            tick();
        end
        @(negedge clk);
        chk("t3_issued", 32'(issued), 4);
        chk("t3_stalled", 32'(b16.txt_rd), 0);
        chk("t3_valid_held", 32'(b16.px_valid), 1);
        chk("t3_no_beats", 32'(q16.size()), 0);
        tick();
        b16.px_ready = 1'b1;
        wait_idle(1, 0, 200);
        check_line(1, 12'h300, 4'd13, 16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
